seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider: integrated remainder register (2*WIDTH), iteration counter, control FSM and start/done handshake in one block.
- Successor to the fixed 32-bit remainder register. Control (shift-left, shift-right, write) is generated internally rather than driven externally.
- Sits beside the ALU in the datapath and serves divide requests from the controller.

---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_div_rem_reg.sv | 57 +++++
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the divide-by-zero quotient fill value.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_rem_reg.sv
// 2*WIDTH remainder register of seq_divider: load, shift-left-with-bit
// (optionally replacing the upper half first) and the final upper-half correction.
module div_rem_reg
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [2*WIDTH-1:0]   i_load_val,
    input  logic                 i_shl,
    input  logic                 i_shl_bit,
    input  logic                 i_wr_hi,
    input  logic [WIDTH-1:0]     i_hi_val,
    input  logic                 i_shr_hi,
    input  logic                 i_neg_hi,
    input  logic                 i_neg_lo,
    output logic                 o_carry,
    output logic [2*WIDTH-1:0]   o_rem
);

    logic [2*WIDTH-1:0] r_rem;
    logic               r_carry;
    logic [2*WIDTH-1:0] w_pre_shift;
    logic [WIDTH-1:0]   w_hi_shr;
    logic [WIDTH-1:0]   w_lo;

    // r_carry keeps the bit shifted out of the top so a partial remainder
    // >= 2^(WIDTH-1) survives the shift; the correction step shifts it back in.
    always_comb begin
        w_pre_shift = {(i_wr_hi ? i_hi_val : r_rem[2*WIDTH-1:WIDTH]), r_rem[WIDTH-1:0]};
        w_hi_shr    = {r_carry, r_rem[2*WIDTH-1:WIDTH+1]};
        w_lo        = r_rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_carry <= 1'b0;
        end else if (i_load) begin
            r_rem   <= i_load_val;
            r_carry <= 1'b0;
        end else if (i_shl) begin
            r_rem   <= {w_pre_shift[2*WIDTH-2:0], i_shl_bit};
            r_carry <= w_pre_shift[2*WIDTH-1];
        end else if (i_shr_hi) begin
            r_rem[2*WIDTH-1:WIDTH] <= i_neg_hi ? -w_hi_shr : w_hi_shr;
            r_rem[WIDTH-1:0]       <= i_neg_lo ? -w_lo : w_lo;
            r_carry                <= 1'b0;
        end
    end

    assign o_carry = r_carry;
    assign o_rem   = r_rem;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with start/done/ack handshake.
// Optional signed operation is enabled by defining SEQ_DIVIDER_SIGNED_EN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend_in,
    input  logic [WIDTH-1:0]     divisor_in,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic                 signed_mode,
`endif
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [WIDTH-1:0]     quotient_out,
    output logic [WIDTH-1:0]     remainder_out,
    output logic [2*WIDTH-1:0]   rem_reg_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_divisor;
    logic                r_div0;
    logic                r_neg_q;
    logic                r_neg_r;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [WIDTH-1:0]    w_a_mag;
    logic [WIDTH-1:0]    w_b_mag;
    logic                w_b_zero;
    logic [WIDTH:0]      w_diff;
    logic                w_borrow;
    logic                w_last;
    logic                w_accept;
    logic                w_load;
    logic [2*WIDTH-1:0]  w_load_val;
    logic                w_shl;
    logic                w_shr;
    logic                w_carry;
    logic [2*WIDTH-1:0]  w_rem;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign w_a_neg = signed_mode & dividend_in[WIDTH-1];
    assign w_b_neg = signed_mode & divisor_in[WIDTH-1];
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
`endif

    always_comb begin
        w_a_mag  = w_a_neg ? -dividend_in : dividend_in;
        w_b_mag  = w_b_neg ? -divisor_in : divisor_in;
        w_b_zero = (divisor_in == '0);
        w_diff   = {w_carry, w_rem[2*WIDTH-1:WIDTH]} - {1'b0, r_divisor};
        w_borrow = w_diff[WIDTH];
        w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_shl       = 1'b0;
        w_shr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                    if (w_b_zero) begin
                        w_load_val  = {dividend_in, {WIDTH{1'b0}}};
                        w_state_nxt = DONE;
                    end else begin
                        w_load_val  = {{(WIDTH-1){1'b0}}, w_a_mag, 1'b0};
                        w_state_nxt = ITER;
                    end
                end
            end
            ITER: begin
                w_shl = 1'b1;
                if (w_last) w_state_nxt = FIX;
            end
            FIX: begin
                w_shr       = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (ack) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_divisor <= '0;
            r_div0    <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt     <= '0;
                r_divisor <= w_b_mag;
                r_div0    <= w_b_zero;
                r_neg_q   <= w_a_neg ^ w_b_neg;
                r_neg_r   <= w_a_neg;
            end else if (r_state == ITER) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    div_rem_reg #(
        .WIDTH (WIDTH)
    ) u_rem_reg (
        .clk        (clk),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_shl      (w_shl),
        .i_shl_bit  (~w_borrow),
        .i_wr_hi    (~w_borrow),
        .i_hi_val   (w_diff[WIDTH-1:0]),
        .i_shr_hi   (w_shr),
        .i_neg_hi   (r_neg_r),
        .i_neg_lo   (r_neg_q),
        .o_carry    (w_carry),
        .o_rem      (w_rem)
    );

    // Divide-by-zero leaves the dividend in the upper half; the quotient is a fixed fill.
    assign busy          = (r_state == ITER) || (r_state == FIX);
    assign done          = (r_state == DONE);
    assign div_by_zero   = (r_state == DONE) && r_div0;
    assign quotient_out  = r_div0 ? DIV0_QUOTIENT[WIDTH-1:0] : w_rem[WIDTH-1:0];
    assign remainder_out = w_rem[2*WIDTH-1:WIDTH];
    assign rem_reg_out   = w_rem;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32) against a behavioural division model.
module tb_seq_divider;

    localparam int unsigned W = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SM_EN = 1'b1;
`else
    localparam bit SM_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   dividend_in = '0;
    logic [W-1:0]   divisor_in = '0;
    logic           signed_mode_v = 1'b0;
    logic           ack = 1'b0;
    logic           busy, done, div_by_zero;
    logic [W-1:0]   quotient_out, remainder_out;
    logic [2*W-1:0] rem_reg_out;

    int n_vec = 0;
    int n_miss = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_mode   (signed_mode_v),
`endif
        .ack           (ack),
        .busy          (busy),
        .done          (done),
        .div_by_zero   (div_by_zero),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .rem_reg_out   (rem_reg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference: unsigned or two's-complement truncating division.
    function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                                      output logic [W-1:0] q, output logic [W-1:0] r);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (sm) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Handshake model: 0 = idle, 1 = working, 2 = result presented.
    int           m_phase = 0;
    int           m_left = 0;
    bit           m_dz = 1'b0;
    logic [W-1:0] m_q = '0;
    logic [W-1:0] m_r = '0;
    logic [2*W-1:0] m_raw = '0;

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0; m_left = 0; m_dz = 1'b0;
            m_q = '0; m_r = '0; m_raw = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    model_div(dividend_in, divisor_in, signed_mode_v & SM_EN, m_q, m_r);
                    if (divisor_in == '0) begin
                        m_phase = 2; m_dz = 1'b1; m_raw = {dividend_in, {W{1'b0}}};
                    end else begin
                        m_phase = 1; m_left = W + 1; m_dz = 1'b0; m_raw = {m_r, m_q};
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
                default: if (ack) begin
                    m_phase = 0; m_dz = 1'b0;
                end
            endcase
        end
        #1;
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        chk("div_by_zero", div_by_zero, (m_phase == 2) && m_dz);
        if (m_phase != 1) begin
            chk("quotient_out", quotient_out, m_q);
            chk("remainder_out", remainder_out, m_r);
            chk("rem_reg_out", rem_reg_out, m_raw);
        end
    end

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                          input int inj, input int ack_wait, input bit noisy,
                          output int lat, output int nbusy,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        @(negedge clk);
        dividend_in = a; divisor_in = b; signed_mode_v = sm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 200) begin
            if (lat == inj) begin
                start = 1'b1; dividend_in = 7; divisor_in = 2;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) nbusy++;
        end
        q = quotient_out; r = remainder_out; dz = div_by_zero;
        repeat (ack_wait) begin
            start = noisy;
            @(negedge clk);
        end
        start = noisy; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
    endtask

    initial begin
        int lat, nb;
        logic [W-1:0] q, r, a, b;
        logic dz;

        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_rem_reg", rem_reg_out, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_div(100, 7, 1'b0, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("lat_100_7", lat, 34);
        chk("busy_cycles_100_7", nb, 33);
        chk("q_100_7", q, 14);
        chk("r_100_7", r, 2);

        do_div(32'hFFFF_FFFF, 1, 1'b0, 0, 1, 1'b0, lat, nb, q, r, dz);
        chk("q_max_1", q, 32'hFFFF_FFFF);
        chk("r_max_1", r, 0);

        do_div(5, 9, 1'b0, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("q_5_9", q, 0);
        chk("r_5_9", r, 5);

        do_div(10, 0, 1'b0, 0, 2, 1'b0, lat, nb, q, r, dz);
        chk("lat_div0", lat, 1);
        chk("dz_div0", dz, 1'b1);
        chk("q_div0", q, 32'hFFFF_FFFF);
        chk("r_div0", r, 10);
        chk("done_after_ack", done, 1'b0);
        chk("dz_after_ack", div_by_zero, 1'b0);
        chk("q_hold_after_ack", quotient_out, 32'hFFFF_FFFF);

        do_div(1000, 3, 1'b0, 4, 10, 1'b1, lat, nb, q, r, dz);
        chk("lat_1000_3", lat, 34);
        chk("q_1000_3", q, 333);
        chk("r_1000_3", r, 1);
        chk("done_held_then_idle", done, 1'b0);
        chk("busy_after_ignored_start", busy, 1'b0);

        @(negedge clk);
        dividend_in = 1000; divisor_in = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_q", quotient_out, 0);
        chk("abort_r", remainder_out, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        do_div(50, 5, 1'b0, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("q_50_5", q, 10);
        chk("r_50_5", r, 0);

        do_div(12, 32'hC000_0001, 1'b0, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("q_small_big", q, 0);
        chk("r_small_big", r, 12);
        do_div(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("r_big_rem", r, 32'hFFFF_FFFE);

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_div(-32'sd7, 2, 1'b1, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("lat_signed", lat, 34);
        chk("q_m7_2", q, -32'sd3);
        chk("r_m7_2", r, -32'sd1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("q_min_m1", q, 32'h8000_0000);
        chk("r_min_m1", r, 0);
        do_div(32'hFFFF_FFF9, 2, 1'b0, 0, 0, 1'b0, lat, nb, q, r, dz);
        chk("q_unsigned_mode", q, 32'h7FFF_FFFC);
        chk("r_unsigned_mode", r, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = $urandom_range(1, 15);
                5:       b = $urandom | 32'h8000_0000;
                6:       b = a >> $urandom_range(0, 4);
                default: b = $urandom;
            endcase
            do_div(a, b, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 3),
                   $urandom_range(0, 1) == 1, lat, nb, q, r, dz);
            chk("lat_rand", lat, (b == '0) ? 1 : 34);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
